// File: rtl/softmax_rowmax_ctrl_pkg.sv
// Shared attention definitions: controller state encoding and FP32 constants.
package softmax_rowmax_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_MAX,
    OUT,
    DONE
  } state_t;

  localparam logic [31:0] FP32_NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;

endpackage

// File: rtl/softmax_rowmax_ctrl_if.sv
// Command, score-buffer, row-max engine and result signals of the row-max controller.
interface softmax_rowmax_ctrl_if #(
  parameter int T      = 4,
  parameter int R_MAX  = 8,
  parameter int ADDR_W = 8
) ();
  localparam int CW = $clog2(T + 1);
  localparam int RW = $clog2(R_MAX + 1);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [RW-1:0]     cmd_rows;
  logic [CW-1:0]     cmd_len;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data;
  logic              eng_in_valid;
  logic              eng_row_start;
  logic              eng_row_last;
  logic [31:0]       eng_in_fp32;
  logic              eng_max_valid;
  logic [31:0]       eng_max_fp32;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_max;
  logic [RW-1:0]     out_row;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_base, cmd_rows, cmd_len, mem_rd_data,
           eng_max_valid, eng_max_fp32, out_ready,
    output cmd_ready, mem_rd_en, mem_rd_addr, eng_in_valid, eng_row_start,
           eng_row_last, eng_in_fp32, out_valid, out_max, out_row, busy, done
  );

  modport master (
    output cmd_valid, cmd_base, cmd_rows, cmd_len, mem_rd_data,
           eng_max_valid, eng_max_fp32, out_ready,
    input  cmd_ready, mem_rd_en, mem_rd_addr, eng_in_valid, eng_row_start,
           eng_row_last, eng_in_fp32, out_valid, out_max, out_row, busy, done
  );
endinterface

// File: rtl/softmax_rowmax_ctrl_addr_gen.sv
// Element/row counters and score-buffer read pointer for the row-max controller.
module rowmax_addr_gen #(
  parameter int CW     = 3,
  parameter int RW     = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              step,
  input  logic              row_next,
  output logic [CW-1:0]     k,
  output logic [RW-1:0]     r,
  output logic [ADDR_W-1:0] addr
);

  // Rows are contiguous, so a free-running pointer equals base + r*len + k
  // without a multiplier; it wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k    <= '0;
      r    <= '0;
      addr <= '0;
    end else if (start) begin
      k    <= '0;
      r    <= '0;
      addr <= base;
    end else begin
      if (step) begin
        k    <= k + CW'(1);
        addr <= addr + ADDR_W'(1);
      end
      if (row_next) begin
        k <= '0;
        r <= r + RW'(1);
      end
    end
  end

endmodule

// File: rtl/softmax_rowmax_ctrl.sv
// Row-max controller: streams each score row to an external row-max engine and returns one max per row.
module softmax_rowmax_ctrl
  import softmax_rowmax_ctrl_pkg::*;
#(
  parameter int T      = 4,
  parameter int R_MAX  = 8,
  parameter int ADDR_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  softmax_rowmax_ctrl_if.slave bus
);
  localparam int CW = $clog2(T + 1);
  localparam int RW = $clog2(R_MAX + 1);

  state_t            state;
  logic [CW-1:0]     len_q, len_sat, k;
  logic [RW-1:0]     rows_q, rows_sat, r;
  logic [ADDR_W-1:0] addr;
  logic              rd_en, last_k, last_row;
  logic              start, step, row_next;
  logic              eng_valid_q, eng_start_q, eng_last_q;
  logic              out_valid_q, done_q;
  logic [31:0]       out_max_q;
  logic [RW-1:0]     out_row_q;

  always_comb begin
    len_sat  = (bus.cmd_len > CW'(T)) ? CW'(T) : bus.cmd_len;
    rows_sat = (bus.cmd_rows > RW'(R_MAX)) ? RW'(R_MAX) : bus.cmd_rows;
  end

  assign last_k   = (k == len_q - CW'(1));
  assign last_row = (r == rows_q - RW'(1));
  assign start    = (state == IDLE) && bus.cmd_valid;
  assign step     = (state == ISSUE);
  assign row_next = (state == OUT) && bus.out_ready && !last_row;

  rowmax_addr_gen #(.CW(CW), .RW(RW), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (bus.cmd_base),
    .step     (step),
    .row_next (row_next),
    .k        (k),
    .r        (r),
    .addr     (addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_q       <= '0;
      rows_q      <= '0;
      rd_en       <= 1'b0;
      out_valid_q <= 1'b0;
      out_max_q   <= FP32_ZERO;
      out_row_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          len_q  <= len_sat;
          rows_q <= rows_sat;
          if (len_sat == '0 || rows_sat == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state <= ISSUE;
            rd_en <= 1'b1;
          end
        end
        ISSUE: if (last_k) begin
          rd_en <= 1'b0;
          state <= WAIT_MAX;
        end
        WAIT_MAX: if (bus.eng_max_valid) begin
          out_max_q   <= bus.eng_max_fp32;
          out_row_q   <= r;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          if (last_row) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state <= ISSUE;
            rd_en <= 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Engine sideband travels with the read strobe so it lines up with the returning data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eng_valid_q <= 1'b0;
      eng_start_q <= 1'b0;
      eng_last_q  <= 1'b0;
    end else begin
      eng_valid_q <= rd_en;
      eng_start_q <= rd_en && (k == '0);
      eng_last_q  <= rd_en && last_k;
    end
  end

  assign bus.cmd_ready     = (state == IDLE);
  assign bus.busy          = (state != IDLE);
  assign bus.done          = done_q;
  assign bus.mem_rd_en     = rd_en;
  assign bus.mem_rd_addr   = addr;
  assign bus.eng_in_valid  = eng_valid_q;
  assign bus.eng_row_start = eng_start_q;
  assign bus.eng_row_last  = eng_last_q;
  assign bus.eng_in_fp32   = eng_valid_q ? bus.mem_rd_data : FP32_ZERO;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_max       = out_max_q;
  assign bus.out_row       = out_row_q;

endmodule
